// File: rtl/gpio_pkg.sv
// Shared register-map constants, register-index enum and address decoder for gpio_ctrl.
package gpio_pkg;

  localparam int unsigned ADDR_BTN_LEVEL = 0;
  localparam int unsigned ADDR_EDGE      = 1;
  localparam int unsigned ADDR_MASK      = 2;
  localparam int unsigned ADDR_LED       = 3;
  localparam int unsigned ADDR_HEX0      = 4;

  localparam int unsigned MAX_HEX = 4;

  typedef enum logic [2:0] {
    RegBtnLevel,
    RegEdge,
    RegMask,
    RegLed,
    RegHex,
    RegNone
  } reg_idx_e;

  // Maps a zero-extended word address onto the register it selects.
  function automatic reg_idx_e addr_decode(input logic [31:0] addr, input int unsigned n_hex);
    reg_idx_e sel;
    if (addr == ADDR_BTN_LEVEL) begin
      sel = RegBtnLevel;
    end else if (addr == ADDR_EDGE) begin
      sel = RegEdge;
    end else if (addr == ADDR_MASK) begin
      sel = RegMask;
    end else if (addr == ADDR_LED) begin
      sel = RegLed;
    end else if ((addr >= ADDR_HEX0) && (addr < (ADDR_HEX0 + n_hex))) begin
      sel = RegHex;
    end else begin
      sel = RegNone;
    end
    return sel;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One button channel: two-flop synchroniser followed by a stable-level debouncer.
module gpio_debounce #(
  parameter int unsigned DEB_CYC = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic level_o
);

  localparam int unsigned CntW = $clog2(DEB_CYC + 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic            level_d;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // The counter only runs while the synchronised input disagrees with the accepted level,
  // so it can never pass DEB_CYC-1 and never wraps.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEB_CYC - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Everything resets to the released (high) level so leaving reset cannot look like a press.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO: debounced buttons with sticky press capture, LED and seven-segment registers.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned N_BTN   = 4,
  parameter int unsigned N_LED   = 18,
  parameter int unsigned N_HEX   = 2,
  parameter int unsigned DEB_CYC = 16,
  parameter int unsigned ADDR_W  = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [N_BTN-1:0]     botones_i,
  input  logic [31:0]          data_in_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic                 rd_en_i,
  input  logic                 wr_en_i,
  output logic [31:0]          data_out_o,
  output logic                 rd_valid_o,
  output logic                 irq_o,
  output logic [N_BTN-1:0]     leds_botones_o,
  output logic [N_LED-1:0]     leds_rojos_o,
  output logic [8*N_HEX-1:0]   hex_o
);

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    gpio_debounce #(
      .DEB_CYC(DEB_CYC)
    ) u_debounce (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .btn_i  (botones_i[i]),
      .level_o(level[i])
    );
  end

  logic [N_BTN-1:0]            prev_q;
  logic [N_BTN-1:0]            status_q;
  logic [N_BTN-1:0]            status_d;
  logic [N_BTN-1:0]            mask_q;
  logic [N_BTN-1:0]            mask_d;
  logic [N_LED-1:0]            led_q;
  logic [N_LED-1:0]            led_d;
  logic [N_HEX-1:0][7:0]       hex_q;
  logic [N_HEX-1:0][7:0]       hex_d;
  logic                        irq_q;
  logic                        irq_d;
  logic [31:0]                 data_out_q;
  logic [31:0]                 data_out_d;
  logic                        rd_valid_q;
  logic                        rd_valid_d;

  logic [31:0] addr_ext;
  logic [31:0] hex_idx;
  reg_idx_e    reg_sel;
  logic [31:0] rdata;

  assign addr_ext = 32'(addr_i);
  assign hex_idx  = addr_ext - ADDR_HEX0;
  assign reg_sel  = addr_decode(addr_ext, N_HEX);

  // A press is a debounced 1->0 transition.
  assign press = prev_q & ~level;

  always_comb begin
    status_d = status_q;
    mask_d   = mask_q;
    led_d    = led_q;
    hex_d    = hex_q;
    if (wr_en_i) begin
      case (reg_sel)
        RegEdge: status_d = status_q & ~data_in_i[N_BTN-1:0];
        RegMask: mask_d   = data_in_i[N_BTN-1:0];
        RegLed:  led_d    = data_in_i[N_LED-1:0];
        RegHex: begin
          for (int k = 0; k < int'(N_HEX); k++) begin
            if (hex_idx == 32'(k)) begin
              hex_d[k] = data_in_i[7:0];
            end
          end
        end
        default: ;
      endcase
    end
    // Applied after the clear so a same-cycle press keeps its bit set.
    status_d = status_d | press;
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      RegBtnLevel: rdata[N_BTN-1:0] = level;
      RegEdge:     rdata[N_BTN-1:0] = status_q;
      RegMask:     rdata[N_BTN-1:0] = mask_q;
      RegLed:      rdata[N_LED-1:0] = led_q;
      RegHex: begin
        for (int k = 0; k < int'(N_HEX); k++) begin
          if (hex_idx == 32'(k)) begin
            rdata[7:0] = hex_q[k];
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    irq_d      = |(status_q & mask_q);
    rd_valid_d = rd_en_i;
    data_out_d = rd_en_i ? rdata : data_out_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q     <= '1;
      status_q   <= '0;
      mask_q     <= '0;
      led_q      <= '0;
      hex_q      <= '0;
      irq_q      <= 1'b0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      prev_q     <= level;
      status_q   <= status_d;
      mask_q     <= mask_d;
      led_q      <= led_d;
      hex_q      <= hex_d;
      irq_q      <= irq_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign data_out_o     = data_out_q;
  assign rd_valid_o     = rd_valid_q;
  assign irq_o          = irq_q;
  assign leds_botones_o = status_q;
  assign leds_rojos_o   = led_q;
  assign hex_o          = hex_q;

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
Parametrised memory-mapped GPIO peripheral. It sits on the processor's simple register bus (addr/rd_en/wr_en) and drives the board LEDs and seven-segment displays. It samples N_BTN active-low push-buttons through a synchroniser and per-channel debouncer, and captures press events into a sticky write-1-to-clear status register. It raises a maskable, level interrupt.

Parameters:
N_BTN, 4, number of push-button inputs (1..32)
N_LED, 18, width of red LED register (1..32)
N_HEX, 2, number of 8-bit seven-segment registers (1..4)
DEB_CYC, 16, consecutive stable cycles needed to accept a new button level (>=2)
ADDR_W, 3, register address width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
botones  in  N_BTN  raw active-low buttons, asynchronous to clk
data_in  in  32  write data
addr  in  ADDR_W  register word address
rd_en  in  1  read strobe
wr_en  in  1  write strobe
data_out  out  32  registered read data
rd_valid  out  1  high the cycle after an accepted read
irq  out  1  registered OR of (EDGE_STATUS & IRQ_MASK)
leds_botones  out  N_BTN  mirror of EDGE_STATUS
leds_rojos  out  N_LED  LED_RED register
hex  out  8*N_HEX  concatenated HEX registers; hex[8k+7:8k] = HEXk

Behaviour:
- One clock domain. reset is sampled only on a clk edge. On reset:
  - data_out=0, rd_valid=0, irq=0.
  - EDGE_STATUS, IRQ_MASK, LED_RED and all HEX registers = 0.
  - Synchroniser flops, debounced level and previous level = all ones (released). Releasing reset must never create a press event.
- Register map (word address):
  - 0 BTN_LEVEL: RO, debounced level, zero-extended.
  - 1 EDGE_STATUS: sticky; writing 1 clears a bit, writing 0 has no effect.
  - 2 IRQ_MASK: RW, N_BTN bits.
  - 3 LED_RED: RW, N_LED bits.
  - 4..4+N_HEX-1 HEXk: RW, 8 bits.
  - Unimplemented bits read 0. Out-of-range addresses read 0 and ignore writes.
- Read path:
  - Latency is 1 cycle. rd_en at cycle t gives data_out and rd_valid=1 at t+1.
  - data_out holds its last value when rd_en=0. rd_valid is a 1-cycle pulse.
- Write path: takes effect at the clock edge where wr_en=1. rd_en and wr_en together at the same address: the read returns the old value.
- Synchroniser: two flops per channel.
- Debouncer (per channel):
  - Counter of width $clog2(DEB_CYC+1).
  - Counter resets to 0 whenever the synchronised input equals the debounced level.
  - Otherwise the counter increments. When it reaches DEB_CYC-1, the debounced level takes the synchronised value and the counter returns to 0.
  - Total latency from a clean input change to the debounced level is 2 + DEB_CYC cycles. A glitch shorter than DEB_CYC cycles is rejected.
- Edge capture: a press is a 1->0 transition of the debounced level. It sets its EDGE_STATUS bit on the next edge. Releases are not captured.
- Simultaneous W1C and new press on the same bit: set wins (bit stays 1). Other bits clear normally.
- irq = registered |(EDGE_STATUS & IRQ_MASK). It is updated every cycle and lags status by 1 cycle.
- Counters saturate by construction and never wrap. Reset in the middle of a debounce discards all partial counts.

Decomposition:
- Package gpio_pkg:
  - Address constants ADDR_BTN_LEVEL=0, ADDR_EDGE=1, ADDR_MASK=2, ADDR_LED=3, ADDR_HEX0=4.
  - Register-index enum.
- Sub-module gpio_debounce:
  - Parameter DEB_CYC.
  - Handles one channel: synchroniser plus counter plus stable level.
  - Instantiated N_BTN times via generate.
- Top level holds the register file, edge capture, irq and read mux.

Test Plan:
- Reset, then read addresses 0..5: data_out = 0x0000000F at addr 0 (defaults N_BTN=4, N_HEX=2); all others read 0. rd_valid pulses for exactly 1 cycle per read.
- Write 0x3FFFF to addr 3 and 0xA5 to addr 4: leds_rojos=18'h3FFFF, hex[7:0]=8'hA5. Write to addr 7: no register changes, read returns 0.
- Hold botones[2]=0 for 30 cycles: debounced bit 2 falls exactly 18 cycles after the input change. EDGE_STATUS reads 0x4 and leds_botones=4'b0100. A 10-cycle low glitch on botones[1] leaves status unchanged.
- IRQ_MASK=0x4 with status bit 2 set: irq=1. Write 0x4 to addr 1: status=0 and irq falls 1 cycle later. Mask 0 with status set: irq stays 0.
- Press on bit 0 completing debounce in the same cycle as a W1C of 0x1: bit 0 remains 1.
- Assert reset while botones[3] is mid-debounce (count 10): after reset, status=0 and no spurious press. A full new DEB_CYC period is required before detection.
